// File: rtl/ushift_pkg.sv
// ushift_pkg: shared definitions for the ushift_seq universal shift register.
//   - Mode encoding on the 2-bit mode input / datapath select.
//   - FSM state encoding for the command sequencer.
package ushift_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHL  = 2'b01;  // toward MSB
    localparam logic [1:0] MODE_SHR  = 2'b10;  // toward LSB
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/ushift_datapath.sv
// ushift_datapath: WIDTH-bit register with a per-bit 4:1 next-value mux.
// Ports:
//   clk, rst     clock, synchronous active-high reset (clears register)
//   sel [1:0]    MODE_HOLD / MODE_SHL / MODE_SHR / MODE_LOAD
//   rot          1: fill bit is the bit shifted out (rotate)
//   ser_r        fill entering LSB on left shift
//   ser_l        fill entering MSB on right shift
//   din          parallel-load data
//   dout         register contents
module ushift_datapath
    import ushift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       sel,
    input  logic             rot,
    input  logic             ser_r,
    input  logic             ser_l,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] dout_q;
    logic [WIDTH-1:0] dout_d;
    logic             fill_l;
    logic             fill_r;

    always_comb begin
        fill_l = rot ? dout_q[WIDTH-1] : ser_r;
        fill_r = rot ? dout_q[0]       : ser_l;
        dout_d = dout_q;
        case (sel)
            MODE_SHL:  dout_d = {dout_q[WIDTH-2:0], fill_l};
            MODE_SHR:  dout_d = {fill_r, dout_q[WIDTH-1:1]};
            MODE_LOAD: dout_d = din;
            default:   dout_d = dout_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) dout_q <= '0;
        else     dout_q <= dout_d;
    end

    assign dout = dout_q;

endmodule

// File: rtl/ushift_seq.sv
// ushift_seq: parametrised universal shift register with command handshake.
// A start in IDLE latches the command; multi-bit shifts run one bit per
// clock in SHIFT, then DONE pulses done for one cycle.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             command strobe (accepted only in IDLE)
//   mode [1:0]        00 hold, 01 shl, 10 shr, 11 load
//   amt [AMT_W-1:0]   shift count, clamped to WIDTH
//   rot               rotate request (only with USHIFT_ROTATE_EN)
//   din [WIDTH-1:0]   parallel-load data
//   ser_r, ser_l      serial fill bits, sampled live on every shift edge
//   dout              register contents
//   busy              FSM not IDLE (registered)
//   done              one-cycle completion pulse (registered)
// Build option: define USHIFT_ROTATE_EN to honour rot; otherwise rot is ignored.
module ushift_seq
    import ushift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [AMT_W-1:0] amt,
    input  logic             rot,
    input  logic [WIDTH-1:0] din,
    input  logic             ser_r,
    input  logic             ser_l,
    output logic [WIDTH-1:0] dout,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [AMT_W-1:0] amt_eff;
    logic [1:0]       dp_sel;
    logic             rot_eff;

`ifdef USHIFT_ROTATE_EN
    logic rot_q, rot_d;
    assign rot_eff = rot_q;
`else
    logic unused_rot;
    assign unused_rot = rot;
    assign rot_eff    = 1'b0;
`endif

    assign amt_eff = (amt > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : amt;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        dp_sel  = MODE_HOLD;
`ifdef USHIFT_ROTATE_EN
        rot_d   = rot_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d = mode;
`ifdef USHIFT_ROTATE_EN
                    rot_d  = rot;
`endif
                    if (mode == MODE_LOAD) begin
                        // load lands on the accept edge itself
                        dp_sel  = MODE_LOAD;
                        state_d = DONE;
                    end else if (mode == MODE_HOLD || amt_eff == '0) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = amt_eff;
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                dp_sel = mode_q;
                cnt_d  = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // status flops are loaded from next-state so they line up with state_q
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= MODE_HOLD;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef USHIFT_ROTATE_EN
            rot_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef USHIFT_ROTATE_EN
            rot_q   <= rot_d;
`endif
        end
    end

    ushift_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk   (clk),
        .rst   (rst),
        .sel   (dp_sel),
        .rot   (rot_eff),
        .ser_r (ser_r),
        .ser_l (ser_l),
        .din   (din),
        .dout  (dout)
    );

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_ushift_seq.sv
// tb_ushift_seq: table vectors, hand-written corner sequences and randomized
// commands checked against an arithmetic reference model of ushift_seq.
module tb_ushift_seq;

    localparam int WIDTH = 8;
    localparam int AMT_W = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [1:0]       mode = 2'b00;
    logic [AMT_W-1:0] amt = '0;
    logic             rot = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic             ser_r = 1'b0;
    logic             ser_l = 1'b0;
    logic [WIDTH-1:0] dout;
    logic             busy;
    logic             done;

    int errors = 0;
    int checks = 0;

    ushift_seq #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .amt(amt),
        .rot(rot), .din(din), .ser_r(ser_r), .ser_l(ser_l),
        .dout(dout), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pre;
        logic [1:0] m;
        logic [3:0] a;
        logic       sr;
        logic       sl;
        logic       r;
        logic [7:0] d;
        logic [7:0] exp_dout;
        int         exp_lat;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

`ifdef USHIFT_ROTATE_EN
    localparam bit ROT_ON = 1'b1;
`else
    localparam bit ROT_ON = 1'b0;
`endif

    // Reference: whole-command result from plain arithmetic, serial bits constant.
    function automatic int model(input int pre, input int m, input int a,
                                 input int sr, input int sl, input int r, input int d);
        int n;
        n = (a > WIDTH) ? WIDTH : a;
        case (m)
            0: return pre;
            3: return d;
            1: if (ROT_ON && r != 0) return ((pre << n) | (pre >> (WIDTH - n))) & 255;
               else return ((pre << n) | (sr != 0 ? (1 << n) - 1 : 0)) & 255;
            default: if (ROT_ON && r != 0) return ((pre >> n) | (pre << (WIDTH - n))) & 255;
               else return (pre >> n) | (sl != 0 ? ((255 << (WIDTH - n)) & 255) : 0);
        endcase
    endfunction

    function automatic int model_lat(input int m, input int a);
        if (m == 1 || m == 2) return (a > WIDTH) ? WIDTH : a;
        return 0;
    endfunction

    // Called at posedge+1; returns dout during the done cycle and edges E0->done.
    task automatic run_cmd(input logic [1:0] m, input logic [3:0] a, input logic [7:0] d,
                           input logic sr, input logic sl, input logic r,
                           output logic [7:0] res, output int lat);
        start = 1'b1; mode = m; amt = a; din = d; ser_r = sr; ser_l = sl; rot = r;
        @(posedge clk); #1;
        start = 1'b0; mode = 2'($urandom); amt = 4'($urandom); din = 8'($urandom);
        chk("busy_after_accept", int'(busy), 1);
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        res = dout;
        chk("busy_in_done", int'(busy), 1);
        @(posedge clk); #1;
        chk("done_one_cycle", int'(done), 0);
        chk("idle_after_done", int'(busy), 0);
    endtask

    initial begin
        logic [7:0] res;
        int lat;
        int m, a, sr, sl, r, pre;
        bit saw_done;

        tbl[0] = '{8'h00, 2'b11, 4'd0,  1'b0, 1'b0, 1'b0, 8'hA5, 8'hA5, 0};
        tbl[1] = '{8'hA5, 2'b01, 4'd3,  1'b1, 1'b0, 1'b0, 8'h00, 8'h2F, 3};
        tbl[2] = '{8'hA5, 2'b10, 4'd2,  1'b0, 1'b0, 1'b0, 8'h00, 8'h29, 2};
        tbl[3] = '{8'hA5, 2'b10, 4'd0,  1'b0, 1'b1, 1'b0, 8'h00, 8'hA5, 0};
        tbl[4] = '{8'h00, 2'b10, 4'd12, 1'b0, 1'b1, 1'b0, 8'h00, 8'hFF, 8};
        tbl[5] = '{8'h3C, 2'b00, 4'd5,  1'b1, 1'b1, 1'b0, 8'h00, 8'h3C, 0};
        tbl[6] = '{8'hFF, 2'b01, 4'd8,  1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8};
        tbl[7] = '{8'h81, 2'b01, 4'd1,  1'b0, 1'b0, 1'b1, 8'h00, ROT_ON ? 8'h03 : 8'h02, 1};
        tbl[8] = '{8'h02, 2'b10, 4'd1,  1'b0, 1'b1, 1'b0, 8'h00, 8'h81, 1};

        // reset, two cycles
        repeat (2) @(posedge clk);
        #1;
        chk("reset_dout", int'(dout), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);

        // rst and start together: rst wins
        start = 1'b1; mode = 2'b11; din = 8'hFF;
        @(posedge clk); #1;
        chk("rst_wins_dout", int'(dout), 0);
        chk("rst_wins_busy", int'(busy), 0);
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;

        // table vectors
        foreach (tbl[i]) begin
            run_cmd(2'b11, 4'd0, tbl[i].pre, 1'b0, 1'b0, 1'b0, res, lat);
            run_cmd(tbl[i].m, tbl[i].a, tbl[i].d, tbl[i].sr, tbl[i].sl, tbl[i].r, res, lat);
            chk($sformatf("vec%0d_dout", i), int'(res), int'(tbl[i].exp_dout));
            chk($sformatf("vec%0d_lat", i), lat, tbl[i].exp_lat);
        end

        // start pulsed during SHIFT is ignored
        run_cmd(2'b11, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, res, lat);
        start = 1'b1; mode = 2'b10; amt = 4'd12; ser_l = 1'b1; ser_r = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1; mode = 2'b11; din = 8'h55; amt = 4'd1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 4;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("ignore_start_dout", int'(dout), 8'hFF);
        chk("ignore_start_lat", lat, 8);
        @(posedge clk); #1;

        // serial input sampled live at each shift edge
        run_cmd(2'b11, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, res, lat);
        start = 1'b1; mode = 2'b10; amt = 4'd2; ser_l = 1'b1;
        @(posedge clk); #1;            // E0
        start = 1'b0;
        @(posedge clk); #1;            // E1 shifted in 1
        ser_l = 1'b0;
        @(posedge clk); #1;            // E2 shifts in 0
        chk("live_serial_dout", int'(dout), 8'h40);
        chk("live_serial_done", int'(done), 1);
        @(posedge clk); #1;

        // reset during a 5-bit shift aborts with no done
        run_cmd(2'b11, 4'd0, 8'hA5, 1'b0, 1'b0, 1'b0, res, lat);
        start = 1'b1; mode = 2'b10; amt = 4'd5; ser_l = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midshift_rst_dout", int'(dout), 0);
        chk("midshift_rst_busy", int'(busy), 0);
        chk("midshift_rst_done", int'(done), 0);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1'b1;
        end
        chk("midshift_rst_no_done", int'(saw_done), 0);

        // randomized commands vs reference model
        for (int k = 0; k < 40; k++) begin
            pre = int'($urandom_range(0, 255));
            m   = int'($urandom_range(0, 3));
            a   = int'($urandom_range(0, 15));
            sr  = int'($urandom_range(0, 1));
            sl  = int'($urandom_range(0, 1));
            r   = int'($urandom_range(0, 1));
            run_cmd(2'b11, 4'd0, 8'(pre), 1'b0, 1'b0, 1'b0, res, lat);
            run_cmd(2'(m), 4'(a), 8'($urandom), 1'(sr), 1'(sl), 1'(r), res, lat);
            if (m == 3) begin
                // loaded data is random; check latency only
                chk($sformatf("rnd%0d_lat", k), lat, 0);
            end else begin
                chk($sformatf("rnd%0d_dout", k), int'(res), model(pre, m, a, sr, sl, r, 0));
                chk($sformatf("rnd%0d_lat", k), lat, model_lat(m, a));
            end
        end

        // random loads checked separately with known data
        for (int k = 0; k < 5; k++) begin
            pre = int'($urandom_range(0, 255));
            run_cmd(2'b11, 4'($urandom), 8'(pre), 1'b0, 1'b0, 1'b0, res, lat);
            chk($sformatf("rndload%0d_dout", k), int'(res), model(0, 3, 0, 0, 0, 0, pre));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ushift_seq.md
# ushift_seq

Parametrised universal shift register with a command handshake. It is the successor to the fixed 4-bit hold/shift-left/shift-right/load register, generalised to WIDTH bits. A single command can shift by a multi-bit amount, executed one bit per clock under a small FSM with busy/done reporting. It sits between a controller issuing shift commands and datapath logic that consumes `dout`.

## Interface
- WIDTH, 8, register width in bits (≥2)
- AMT_W, $clog2(WIDTH+1), width of shift-amount input
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  synchronous, active-high reset
- start  in  1  command strobe; accepted only in IDLE
- mode  in  2  00 hold, 01 shift left (toward MSB), 10 shift right (toward LSB), 11 parallel load
- amt  in  AMT_W  shift count for modes 01/10
- rot  in  1  rotate instead of serial fill; only effective with USHIFT_ROTATE_EN
- din  in  WIDTH  parallel-load data
- ser_r  in  1  fill bit entering LSB on left shift
- ser_l  in  1  fill bit entering MSB on right shift
- dout  out  WIDTH  register contents
- busy  out  1  high whenever FSM is not IDLE
- done  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE + start at edge E0: latch mode, rot, amt_eff = min(amt, WIDTH).
  - mode 11: dout ← din at E0; go to DONE.
  - mode 00, or amt_eff = 0: dout unchanged; go to DONE.
  - mode 01/10 with amt_eff > 0: cnt ← amt_eff; go to SHIFT.
- SHIFT: each edge performs one step and decrements cnt. When cnt reaches 0, go to DONE.
  - Left step: dout ← {dout[WIDTH-2:0], fill}; fill = ser_r, or dout[WIDTH-1] when rotating.
  - Right step: dout ← {fill, dout[WIDTH-1:1]}; fill = ser_l, or dout[0] when rotating.
- Serial inputs are sampled live at every shifting edge, not latched at start.
- DONE: done = 1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored; there is no queueing. mode/amt/din are don't-care outside the accept edge.
- amt > WIDTH clamps to WIDTH.

## Timing
- Reset (synchronous, any state, including mid-shift): dout = 0, busy = 0, done = 0, cnt = 0, state IDLE. The operation in flight is aborted with no done pulse.
- Load/hold/zero-amount: dout updated at E0 (load); done high in the cycle after E0; IDLE after E1. A new start is accepted at E2 at the earliest.
- Shift by n: shift edges E1…En; done high in the cycle after En; busy high from after E0 through the DONE cycle.
- busy and done are registered outputs with no combinational path from inputs.
- rst and start asserted together: rst wins.

## Configuration
- USHIFT_ROTATE_EN defined: rot latched at accept; when 1, the fill bit is the bit shifted out, giving a rotate.
- USHIFT_ROTATE_EN undefined: rot port present but ignored; fill always comes from ser_r/ser_l.

## Structure
- Package ushift_pkg holds:
  - mode encoding constants: MODE_HOLD = 2'b00, MODE_SHL = 2'b01, MODE_SHR = 2'b10, MODE_LOAD = 2'b11.
  - FSM state enum: IDLE/SHIFT/DONE.
- One sub-module, ushift_datapath: holds the WIDTH-bit register and its per-bit 4:1 next-value mux (hold/left/right/load plus fill select). The top level contains the FSM and counter and drives the datapath select.

## Test plan
- Reset: rst high for 2 cycles -> dout = 0x00, busy = 0, done = 0. Assert rst during a 5-bit shift -> dout = 0x00 next cycle, no done pulse.
- Load: WIDTH=8, start, mode=11, din=0xA5 -> dout = 0xA5 after E0, done pulse in the next cycle, busy deasserts after E1.
- Left shift: dout=0xA5, mode=01, amt=3, ser_r=1 -> dout = 0x2F after E3, done in the cycle after E3.
- Right shift: dout=0xA5, mode=10, amt=2, ser_l=0 -> dout = 0x29. Repeat with amt=0 -> dout stays 0xA5, done after E0.
- Clamp and ignore: dout=0x00, mode=10, amt=12, ser_l=1 -> exactly 8 shifts, dout = 0xFF, done after E8. A start pulsed during SHIFT changes nothing.
- Rotate, with USHIFT_ROTATE_EN: dout=0x81, mode=01, rot=1, amt=1, ser_r=0 -> dout = 0x03. Without the macro -> dout = 0x02.
